// File: rtl/cpu_core.sv
// cpu_core: parametrised two-cycle fetch/execute CPU with 4 registers, Z/C flags, load/store and halt
module cpu_core #(
    parameter int BW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   cin,
    input  logic [BW-1:0] din,
    output logic [AW-1:0] addr,
    output logic [BW-1:0] dout,
    output logic          we,
    output logic          halted
);
    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [15:0]   r_ir;
    logic [BW-1:0] r_regs [4];
    logic          r_z, r_c;
    logic [BW-1:0] r_dout;
    logic [3:0]    w_op;
    logic [1:0]    w_rd, w_rs;
    logic [AW-1:0] w_imm;
    logic [BW-1:0] w_a, w_b;
    logic [BW:0]   w_res;
    logic          w_exec, w_mem, w_wr, w_fl, w_jmp;
    assign w_op   = r_ir[15:12];
    assign w_rd   = r_ir[11:10];
    assign w_rs   = r_ir[9:8];
    assign w_imm  = AW'(r_ir[7:0]);
    assign w_a    = r_regs[w_rd];
    assign w_b    = r_regs[w_rs];
    assign w_exec = r_state == EXEC;
    assign w_mem  = w_op == 4'h9 || w_op == 4'hA;
    assign w_wr   = (w_op >= 4'h1 && w_op <= 4'h9) || w_op == 4'hE;
    assign w_fl   = w_op >= 4'h2 && w_op <= 4'h8;
    assign w_jmp  = w_op == 4'hB || (w_op == 4'hC && r_z) || (w_op == 4'hD && r_c);
    assign addr   = rst ? '0 : (w_exec && w_mem) ? w_imm : r_pc;
    assign we     = !rst && w_exec && w_op == 4'hA;
    assign halted = !rst && r_state == HALT;
    assign dout   = r_dout;
    always_comb begin
        w_res = {1'b0, w_a};
        case (w_op)
            4'h1:    w_res = {1'b0, BW'(r_ir[7:0])};
            4'h2:    w_res = {1'b0, w_a} + {1'b0, w_b};
            4'h3:    w_res = {1'b0, w_a} - {1'b0, w_b};
            4'h4:    w_res = {1'b0, w_a & w_b};
            4'h5:    w_res = {1'b0, w_a | w_b};
            4'h6:    w_res = {1'b0, w_a ^ w_b};
            4'h7:    w_res = {w_a, 1'b0};
            4'h8:    w_res = {w_a[0], 1'b0, w_a[BW-1:1]};
            4'h9:    w_res = {1'b0, din};
            4'hE:    w_res = {1'b0, w_b};
            default: w_res = {1'b0, w_a};
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_dout  <= '0;
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
        end else if (r_state == FETCH) begin
            r_ir    <= cin;
            r_state <= EXEC;
        end else if (w_exec) begin
            r_pc    <= w_jmp ? w_imm : r_pc + AW'(1);
            r_state <= w_op == 4'hF ? HALT : FETCH;
            if (w_wr) r_regs[w_rd] <= w_res[BW-1:0];
            if (w_fl) begin
                r_c <= w_res[BW];
                r_z <= w_res[BW-1:0] == '0;
            end
            if (w_op == 4'hA) r_dout <= w_b;
        end
    end
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: table-driven ALU/flag vectors plus hand sequences, store scoreboard on we/addr/dout
module tb_cpu_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cin, din, dout;
    logic [7:0]  addr;
    logic        we, halted;
    logic [15:0] rom [256];
    logic [15:0] dmem [256];
    int          errs = 0;
    int          checks = 0;
    typedef struct {logic [7:0] a; logic [15:0] d;} st_t;
    typedef struct {logic [3:0] op; logic [7:0] a; logic [7:0] b; logic [7:0] sa; logic [15:0] v;} vec_t;
    st_t         q[$];
    logic        dpend = 1'b0;
    logic [15:0] dexp;
    vec_t        vt [14];

    cpu_core #(.BW(16), .AW(8)) dut (
        .clk(clk), .rst(rst), .cin(cin), .din(din),
        .addr(addr), .dout(dout), .we(we), .halted(halted)
    );

    always #5 clk = ~clk;
    assign cin = rom[addr];
    assign din = dmem[addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    always @(negedge clk) begin : mon
        st_t e;
        if (dpend) begin
            chk("st_data", 32'(dout), 32'(dexp));
            dpend = 1'b0;
        end
        if (we) begin
            if (q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_store: addr %0h dout-to-be unknown, no store expected", addr);
            end else begin
                e = q.pop_front();
                chk("st_addr", 32'(addr), 32'(e.a));
                dexp  = e.d;
                dpend = 1'b1;
            end
        end
    end

    task automatic clear_mem();
        foreach (rom[i]) rom[i] = 16'hF000;
        foreach (dmem[i]) dmem[i] = 16'h0000;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        q.delete();
        dpend = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_halted", 32'(halted), 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_to_halt(input int budget);
        for (int k = 0; k < budget && !halted; k++) @(negedge clk);
        chk("halt_reached", 32'(halted), 1);
        chk("stores_left", q.size(), 0);
    endtask

    task automatic load_vec(input vec_t v);
        clear_mem();
        rom[0]    = ins(4'h1, 2'd0, 2'd0, v.a);
        rom[1]    = ins(4'h1, 2'd1, 2'd0, v.b);
        rom[2]    = ins(v.op, 2'd0, 2'd1, 8'h00);
        rom[3]    = ins(4'hC, 2'd0, 2'd0, 8'h10);
        rom[4]    = ins(4'hD, 2'd0, 2'd0, 8'h30);
        rom[5]    = ins(4'hA, 2'd0, 2'd0, 8'h40);
        rom[8'h10] = ins(4'hD, 2'd0, 2'd0, 8'h50);
        rom[8'h11] = ins(4'hA, 2'd0, 2'd0, 8'h41);
        rom[8'h30] = ins(4'hA, 2'd0, 2'd0, 8'h42);
        rom[8'h50] = ins(4'hA, 2'd0, 2'd0, 8'h43);
    endtask

    initial begin
        // store address 0x40 + {C,Z} encodes the flags left by the op under test
        vt[0]  = '{4'h2, 8'h05, 8'h03, 8'h40, 16'h0008};
        vt[1]  = '{4'h2, 8'h00, 8'h00, 8'h41, 16'h0000};
        vt[2]  = '{4'h3, 8'h04, 8'h04, 8'h41, 16'h0000};
        vt[3]  = '{4'h3, 8'h03, 8'h05, 8'h42, 16'hFFFE};
        vt[4]  = '{4'h4, 8'hF0, 8'h0F, 8'h41, 16'h0000};
        vt[5]  = '{4'h5, 8'hF0, 8'h0F, 8'h40, 16'h00FF};
        vt[6]  = '{4'h6, 8'hAA, 8'hAA, 8'h41, 16'h0000};
        vt[7]  = '{4'h6, 8'hAA, 8'h55, 8'h40, 16'h00FF};
        vt[8]  = '{4'h7, 8'h81, 8'h00, 8'h40, 16'h0102};
        vt[9]  = '{4'h8, 8'h01, 8'h00, 8'h43, 16'h0000};
        vt[10] = '{4'h8, 8'h80, 8'h00, 8'h40, 16'h0040};
        vt[11] = '{4'hE, 8'h07, 8'h09, 8'h40, 16'h0009};
        vt[12] = '{4'h0, 8'h07, 8'h09, 8'h40, 16'h0007};
        vt[13] = '{4'h1, 8'h07, 8'h09, 8'h40, 16'h0000};
        clear_mem();
        do_reset(3);
        for (int i = 0; i < 14; i++) begin
            load_vec(vt[i]);
            do_reset(1);
            q.push_back('{vt[i].sa, vt[i].v});
            run_to_halt(40);
        end
        // reset asserted during the EXEC of a store: no store, state cleared, restart at 0
        load_vec(vt[0]);
        do_reset(1);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t1_addr", 32'(addr), 0);
            chk("t1_we", 32'(we), 0);
            chk("t1_dout", 32'(dout), 0);
            chk("t1_halted", 32'(halted), 0);
            @(posedge clk);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t1_fetch0", 32'(addr), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t1_fetch1", 32'(addr), 1);
        // ADD then ST at cycle 7
        clear_mem();
        rom[0] = ins(4'h1, 2'd0, 2'd0, 8'h05);
        rom[1] = ins(4'h1, 2'd1, 2'd0, 8'h03);
        rom[2] = ins(4'h2, 2'd0, 2'd1, 8'h00);
        rom[3] = ins(4'hA, 2'd0, 2'd0, 8'h20);
        do_reset(2);
        q.push_back('{8'h20, 16'h0008});
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("t2_we_cycle7", 32'(we), 1);
        run_to_halt(20);
        // carry out of the top bit: 0-1 = FFFF (C), FFFF+1 = 0 (Z,C), JC then JZ taken
        clear_mem();
        rom[0]     = ins(4'h1, 2'd0, 2'd0, 8'h00);
        rom[1]     = ins(4'h1, 2'd1, 2'd0, 8'h01);
        rom[2]     = ins(4'h3, 2'd0, 2'd1, 8'h00);
        rom[3]     = ins(4'h2, 2'd0, 2'd1, 8'h00);
        rom[4]     = ins(4'hD, 2'd0, 2'd0, 8'h40);
        rom[5]     = ins(4'hA, 2'd0, 2'd0, 8'h21);
        rom[8'h40] = ins(4'hC, 2'd0, 2'd0, 8'h44);
        rom[8'h41] = ins(4'hA, 2'd0, 2'd0, 8'h22);
        rom[8'h44] = ins(4'hA, 2'd0, 2'd0, 8'h23);
        do_reset(1);
        q.push_back('{8'h23, 16'h0000});
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t3_jc_target", 32'(addr), 32'h40);
        run_to_halt(30);
        // JZ taken after SUB 4-4, then JC with C=0 falls through
        clear_mem();
        rom[0]     = ins(4'h1, 2'd0, 2'd0, 8'h04);
        rom[1]     = ins(4'h1, 2'd1, 2'd0, 8'h04);
        rom[2]     = ins(4'h3, 2'd0, 2'd1, 8'h00);
        rom[3]     = ins(4'hC, 2'd0, 2'd0, 8'h10);
        rom[4]     = ins(4'hA, 2'd0, 2'd0, 8'h50);
        rom[8'h10] = ins(4'hD, 2'd0, 2'd0, 8'h30);
        rom[8'h11] = ins(4'hA, 2'd0, 2'd0, 8'h24);
        rom[8'h30] = ins(4'hA, 2'd0, 2'd0, 8'h25);
        do_reset(1);
        q.push_back('{8'h24, 16'h0000});
        run_to_halt(30);
        // pc wraps from 0xFF to 0x00
        clear_mem();
        rom[0]     = ins(4'hB, 2'd0, 2'd0, 8'hFF);
        rom[8'hFF] = 16'h0000;
        do_reset(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t5_jmp_ff", 32'(addr), 32'hFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t5_wrap", 32'(addr), 0);
        // LD from data memory, then ADD with rd==rs
        clear_mem();
        dmem[8'h33] = 16'h1234;
        rom[0] = ins(4'h9, 2'd2, 2'd0, 8'h33);
        rom[1] = ins(4'hA, 2'd0, 2'd2, 8'h26);
        rom[2] = ins(4'h1, 2'd3, 2'd0, 8'h40);
        rom[3] = ins(4'h2, 2'd3, 2'd3, 8'h00);
        rom[4] = ins(4'hA, 2'd0, 2'd3, 8'h27);
        do_reset(1);
        q.push_back('{8'h26, 16'h1234});
        q.push_back('{8'h27, 16'h0080});
        @(posedge clk);
        @(negedge clk);
        chk("t5_ld_addr", 32'(addr), 32'h33);
        run_to_halt(30);
        // HLT at address 5
        clear_mem();
        for (int i = 0; i < 5; i++) rom[i] = 16'h0000;
        do_reset(1);
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("t6_not_yet_halted", 32'(halted), 0);
        @(posedge clk);
        @(negedge clk);
        chk("t6_halted_c12", 32'(halted), 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("t6_halt_addr", 32'(addr), 6);
            chk("t6_halt_we", 32'(we), 0);
        end
        do_reset(2);
        @(negedge clk);
        chk("t6_rst_clears", 32'(halted), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
